// File: rtl/vfu_mem_pkg.sv
// Shared types and helpers for the vector-unit memory responder.
package vfu_mem_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 32;
  // Byte offset bits inside one DATA_WIDTH word.
  localparam int ADDR_LSB   = 3;

  // One read response as it travels down the pipe and through the queue.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } resp_t;

  // A request is bad when it is not word aligned or its word index falls
  // outside the scratchpad. Arguments are widened so any address width fits.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth);
    return (addr[ADDR_LSB-1:0] != '0) || ((addr >> ADDR_LSB) >= depth);
  endfunction

endpackage

// File: rtl/vfu_resp_fifo.sv
// In-order response queue. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB; storage itself is never reset.
module vfu_resp_fifo
  import vfu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  resp_t push_data_i,
  input  logic  pop_i,
  output resp_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  resp_t       mem_q [DEPTH];

  logic do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  // Pointer registers, cleared asynchronously so the queue empties at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/vfu_mem_responder.sv
// Memory-side responder for the vector unit's 64-bit port: word scratchpad,
// fixed-latency read pipe and credit-gated in-order response queue.
// Optional byte strobes: define VFU_MEM_WSTRB_EN to add mem_port_wstrb.
module vfu_mem_responder
  import vfu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = vfu_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = vfu_mem_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 512,
  parameter int READ_LAT   = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_port_req,
  output logic                    mem_port_req_ready,
  input  logic                    mem_port_wr,
  input  logic [ADDR_WIDTH-1:0]   mem_port_addr,
  input  logic [DATA_WIDTH-1:0]   mem_port_wdata,
`ifdef VFU_MEM_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] mem_port_wstrb,
`endif
  output logic [DATA_WIDTH-1:0]   mem_port_rdata,
  output logic                    mem_port_rerr,
  output logic                    mem_port_rvalid,
  input  logic                    mem_port_rready,
  output logic                    wr_err_sticky
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;
  // Stage 0 is the accept cycle itself; the rest are registered.
  localparam int STAGES = READ_LAT - 1;

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             wr_err_sticky_q, wr_err_sticky_d;

  logic             acc, rd_acc, wr_acc, req_err, pop;
  logic [IDX_W-1:0] idx;
  resp_t            rd_resp, push_resp, head;
  logic             fifo_push, fifo_full, fifo_empty;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Credit gate covers writes too so there is only one acceptance rule.
  assign mem_port_req_ready = !reset && (outstanding_q < CNT_W'(RESP_DEPTH));
  assign acc     = mem_port_req && mem_port_req_ready;
  assign rd_acc  = acc && !mem_port_wr;
  assign wr_acc  = acc &&  mem_port_wr;
  assign req_err = addr_err(64'(mem_port_addr), 64'(DEPTH));
  assign idx     = mem_port_addr[ADDR_LSB +: IDX_W];

  // Scratchpad write; bad writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !req_err) begin
`ifdef VFU_MEM_WSTRB_EN
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (mem_port_wstrb[b]) mem_q[idx][b*8 +: 8] <= mem_port_wdata[b*8 +: 8];
      end
`else
      mem_q[idx] <= mem_port_wdata;
`endif
    end
  end

  // Storage is read in the accept cycle; errors return zero data.
  always_comb begin
    rd_resp      = '0;
    rd_resp.err  = req_err;
    if (!req_err) rd_resp.data = mem_q[idx];
  end

  generate
    if (STAGES == 0) begin : g_no_pipe
      assign fifo_push = rd_acc;
      assign push_resp = rd_resp;
    end else begin : g_pipe
      logic  [STAGES:1] vld_pipe_q;
      resp_t            resp_pipe_q [STAGES:1];

      // Valid/data shift pipe; reset discards anything in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_pipe_q <= '0;
          for (int k = 1; k <= STAGES; k++) resp_pipe_q[k] <= '0;
        end else begin
          vld_pipe_q[1]  <= rd_acc;
          resp_pipe_q[1] <= rd_resp;
          for (int k = 2; k <= STAGES; k++) begin
            vld_pipe_q[k]  <= vld_pipe_q[k-1];
            resp_pipe_q[k] <= resp_pipe_q[k-1];
          end
        end
      end

      assign fifo_push = vld_pipe_q[STAGES];
      assign push_resp = resp_pipe_q[STAGES];
    end
  endgenerate

  vfu_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_data_i(push_resp),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mem_port_rvalid = !fifo_empty;
  assign pop             = mem_port_rvalid && mem_port_rready;
  // Zero the data lines whenever nothing valid is presented.
  assign mem_port_rdata  = mem_port_rvalid ? head.data : '0;
  assign mem_port_rerr   = mem_port_rvalid && head.err;
  assign wr_err_sticky   = wr_err_sticky_q;

  // Outstanding reads: +1 on read accept, -1 on pop.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_acc, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sticky write-error flag, cleared only by reset.
  always_comb begin
    wr_err_sticky_d = wr_err_sticky_q | (wr_acc & req_err);
  end

  // Credit counter and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q   <= '0;
      wr_err_sticky_q <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_d;
      wr_err_sticky_q <= wr_err_sticky_d;
    end
  end

endmodule

// File: tb/tb_vfu_mem_responder.sv
// Self-checking bench for vfu_mem_responder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_vfu_mem_responder;

  localparam int DW = 64, AW = 32, DEPTH = 512, READ_LAT = 2, RESP_DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_port_req = 1'b0, mem_port_wr = 1'b0, mem_port_rready = 1'b0;
  logic [AW-1:0] mem_port_addr = '0;
  logic [DW-1:0] mem_port_wdata = '0;
  logic [DW/8-1:0] mem_port_wstrb = '1;
  logic          mem_port_req_ready, mem_port_rerr, mem_port_rvalid, wr_err_sticky;
  logic [DW-1:0] mem_port_rdata;

  always #5 clk = ~clk;

  vfu_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_port_req(mem_port_req), .mem_port_req_ready(mem_port_req_ready),
    .mem_port_wr(mem_port_wr), .mem_port_addr(mem_port_addr), .mem_port_wdata(mem_port_wdata),
`ifdef VFU_MEM_WSTRB_EN
    .mem_port_wstrb(mem_port_wstrb),
`endif
    .mem_port_rdata(mem_port_rdata), .mem_port_rerr(mem_port_rerr),
    .mem_port_rvalid(mem_port_rvalid), .mem_port_rready(mem_port_rready),
    .wr_err_sticky(wr_err_sticky)
  );

  // Reference model: word array plus queue of expected responses in order.
  typedef struct { logic [63:0] d; logic e; int acc; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] mdl [DEPTH];
  logic [7:0]  wstrb_v = 8'hFF;
  int cyc = 0, n_cmp = 0, n_err = 0;

  function automatic bit exp_rvalid();
    return exp_q.size() > 0 && cyc >= exp_q[0].acc + READ_LAT;
  endfunction
  function automatic bit exp_ready();
    return exp_q.size() < RESP_DEPTH;
  endfunction

  // The queue must never be pushed while full.
  always @(negedge clk) begin
    if (!reset && dut.fifo_push && dut.fifo_full) begin
      n_err++;
      $display("FAIL push_while_full: push=1 full=1 at cycle %0d, required no push", cyc);
    end
  end

  // One cycle: drive at negedge, decide accept/pop, update model, advance.
  task automatic step(input bit req, input bit wr, input logic [31:0] a, input logic [63:0] wd,
                      input bit rr, output bit acc, output bit pop, output logic [63:0] rd,
                      output logic re, output exp_t ex);
    bit err; int idx;
    mem_port_req = req; mem_port_wr = wr; mem_port_addr = a; mem_port_wdata = wd;
    mem_port_rready = rr; mem_port_wstrb = wstrb_v;
    #1;
    acc = req && (mem_port_req_ready === 1'b1);
    pop = (mem_port_rvalid === 1'b1) && rr;
    rd  = mem_port_rdata; re = mem_port_rerr;
    ex  = '{d: '0, e: 1'b0, acc: 0};
    if (pop && exp_q.size() > 0) ex = exp_q.pop_front();
    err = (a % 8 != 0) || (a / 8 >= DEPTH);
    idx = int'((a / 8) % DEPTH);
    if (acc && wr && !err) begin
      for (int b = 0; b < 8; b++) if (wstrb_v[b]) mdl[idx][b*8 +: 8] = wd[b*8 +: 8];
    end else if (acc && !wr) begin
      exp_q.push_back('{d: err ? 64'h0 : mdl[idx], e: err, acc: cyc});
    end
    @(negedge clk);
    cyc++;
  endtask

  bit acc, pop; logic [63:0] rd; logic re; exp_t ex;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_port_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", mem_port_rvalid); end
    n_cmp++; if (mem_port_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", mem_port_rdata); end
    n_cmp++; if (mem_port_rerr !== 1'b0) begin n_err++; $display("FAIL rst_rerr: got %b want 0", mem_port_rerr); end
    n_cmp++; if (wr_err_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sticky: got %b want 0", wr_err_sticky); end
    n_cmp++; if (mem_port_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", mem_port_req_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_port_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", mem_port_req_ready); end
  endtask

  task automatic test_basic();
    int tacc;
    step(1, 1, 32'h10, 64'hDEADBEEF_CAFEF00D, 1, acc, pop, rd, re, ex);
    tacc = cyc;
    step(1, 0, 32'h10, 64'h0, 1, acc, pop, rd, re, ex);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", acc); end
    for (int k = 0; k < 10 && mem_port_rvalid !== 1'b1; k++) step(0, 0, 0, 0, 0, acc, pop, rd, re, ex);
    n_cmp++; if (cyc - tacc !== READ_LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", cyc - tacc, READ_LAT); end
    step(0, 0, 0, 0, 1, acc, pop, rd, re, ex);
    n_cmp++; if (pop !== 1'b1 || rd !== 64'hDEADBEEF_CAFEF00D || re !== 1'b0) begin
      n_err++; $display("FAIL basic_data: got pop=%b %h err=%b want pop=1 deadbeefcafef00d err=0", pop, rd, re);
    end
  endtask

  task automatic test_back_to_back();
    int t0, nxt, got;
    for (int i = 0; i < 8; i++) step(1, 1, 32'(i*8), 64'(i), 1, acc, pop, rd, re, ex);
    t0 = cyc; nxt = 0; got = 0;
    for (int k = 0; k < 80 && got < 6; k++) begin
      if (cyc == t0 + 7) begin
        n_cmp++; if (mem_port_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", mem_port_req_ready); end
        n_cmp++; if (nxt !== 4) begin n_err++; $display("FAIL bp_accepts: got %0d want 4", nxt); end
      end
      step(nxt < 6, 0, 32'(nxt*8), 0, cyc >= t0 + 8, acc, pop, rd, re, ex);
      if (acc) nxt++;
      if (pop) begin
        n_cmp++; if (rd !== 64'(got) || re !== 1'b0) begin n_err++; $display("FAIL bp_order: got %h err=%b want %h err=0", rd, re, 64'(got)); end
        got++;
      end
    end
    n_cmp++; if (got !== 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", got); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [2] = '{32'h13, 32'h1000};
    for (int j = 0; j < 2; j++) begin
      pop = 0;
      for (int k = 0; k < 10 && !pop; k++) step(k == 0, 0, addrs[j], 0, 1, acc, pop, rd, re, ex);
      n_cmp++; if (pop !== 1'b1 || rd !== 64'h0 || re !== 1'b1) begin
        n_err++; $display("FAIL err_read_%0d: got pop=%b %h err=%b want pop=1 0 err=1", j, pop, rd, re);
      end
    end
    n_cmp++; if (wr_err_sticky !== 1'b0) begin n_err++; $display("FAIL err_sticky_pre: got %b want 0", wr_err_sticky); end
    step(1, 1, 32'(DEPTH*8), 64'hFF, 1, acc, pop, rd, re, ex);
    n_cmp++; if (wr_err_sticky !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", wr_err_sticky); end
    pop = 0;
    for (int k = 0; k < 10 && !pop; k++) step(k == 0, 0, 32'h0, 0, 1, acc, pop, rd, re, ex);
    n_cmp++; if (pop !== 1'b1 || rd !== 64'h0 || re !== 1'b0) begin
      n_err++; $display("FAIL err_word0_kept: got pop=%b %h err=%b want pop=1 0 err=0", pop, rd, re);
    end
  endtask

  task automatic test_credit();
    for (int i = 0; i < 4; i++) step(1, 0, 32'((i+1)*8), 0, 0, acc, pop, rd, re, ex);
    repeat (3) step(0, 0, 0, 0, 0, acc, pop, rd, re, ex);
    n_cmp++; if (mem_port_req_ready !== 1'b0 || mem_port_rvalid !== 1'b1) begin
      n_err++; $display("FAIL cr_full: got ready=%b rvalid=%b want ready=0 rvalid=1", mem_port_req_ready, mem_port_rvalid);
    end
    step(0, 0, 0, 0, 1, acc, pop, rd, re, ex);
    n_cmp++; if (mem_port_req_ready !== 1'b1) begin n_err++; $display("FAIL cr_freed: got %b want 1", mem_port_req_ready); end
    step(1, 0, 32'h28, 0, 1, acc, pop, rd, re, ex);
    n_cmp++; if ({acc, pop} !== 2'b11 || mem_port_req_ready !== 1'b1) begin
      n_err++; $display("FAIL cr_same: got acc=%b pop=%b ready=%b want 1 1 1", acc, pop, mem_port_req_ready);
    end
    step(1, 0, 32'h8, 0, 0, acc, pop, rd, re, ex);
    n_cmp++; if (mem_port_req_ready !== 1'b0) begin n_err++; $display("FAIL cr_refull: got %b want 0", mem_port_req_ready); end
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      step(0, 0, 0, 0, 1, acc, pop, rd, re, ex);
      if (pop) begin
        n_cmp++; if (rd !== ex.d || re !== ex.e) begin n_err++; $display("FAIL cr_drain: got %h/%b want %h/%b", rd, re, ex.d, ex.e); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a; bit rq, wr;
    for (int i = 0; i < 8; i++) step(1, 1, 32'(i*8), {$urandom, $urandom}, 1, acc, pop, rd, re, ex);
    for (int n = 0; n < 400; n++) begin
      n_cmp++; if (mem_port_req_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, mem_port_req_ready, exp_ready()); end
      n_cmp++; if (mem_port_rvalid !== exp_rvalid()) begin n_err++; $display("FAIL rnd_rvalid: cyc %0d got %b want %b", cyc, mem_port_rvalid, exp_rvalid()); end
      rq = $urandom_range(0, 99) < 60;
      wr = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 7)*8 + $urandom_range(1, 7));
        1:       a = 32'(DEPTH*8 + $urandom_range(0, 7)*8);
        default: a = 32'($urandom_range(0, 7)*8);
      endcase
      step(rq, wr, a, {$urandom, $urandom}, $urandom_range(0, 3) != 0, acc, pop, rd, re, ex);
      if (pop) begin
        n_cmp++; if (rd !== ex.d || re !== ex.e) begin n_err++; $display("FAIL rnd_data: got %h/%b want %h/%b", rd, re, ex.d, ex.e); end
      end
    end
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      step(0, 0, 0, 0, 1, acc, pop, rd, re, ex);
      if (pop) begin
        n_cmp++; if (rd !== ex.d || re !== ex.e) begin n_err++; $display("FAIL rnd_drain: got %h/%b want %h/%b", rd, re, ex.d, ex.e); end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rnd_leftover: got %0d want 0", exp_q.size()); end
  endtask

`ifdef VFU_MEM_WSTRB_EN
  task automatic test_wstrb();
    step(1, 1, 32'h0, 64'h0, 1, acc, pop, rd, re, ex);
    wstrb_v = 8'h0F;
    step(1, 1, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 1, acc, pop, rd, re, ex);
    wstrb_v = 8'hFF;
    pop = 0;
    for (int k = 0; k < 10 && !pop; k++) step(k == 0, 0, 32'h0, 0, 1, acc, pop, rd, re, ex);
    n_cmp++; if (pop !== 1'b1 || rd !== 64'h00000000_FFFFFFFF) begin
      n_err++; $display("FAIL wstrb_merge: got pop=%b %h want pop=1 00000000ffffffff", pop, rd);
    end
  endtask
`endif

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) step(1, 0, 32'(i*8), 0, 0, acc, pop, rd, re, ex);
    n_cmp++; if (mem_port_rvalid !== 1'b1 || wr_err_sticky !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got rvalid=%b sticky=%b want 1 1", mem_port_rvalid, wr_err_sticky);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (mem_port_rvalid !== 1'b0 || mem_port_req_ready !== 1'b0 || mem_port_rdata !== 64'h0) begin
      n_err++; $display("FAIL mid_async: got rvalid=%b ready=%b rdata=%h want 0 0 0", mem_port_rvalid, mem_port_req_ready, mem_port_rdata);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 1, acc, pop, rd, re, ex);
      n_cmp++; if (mem_port_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got rvalid=%b want 0", mem_port_rvalid); end
    end
    n_cmp++; if (mem_port_req_ready !== 1'b1 || wr_err_sticky !== 1'b0) begin
      n_err++; $display("FAIL mid_idle: got ready=%b sticky=%b want 1 0", mem_port_req_ready, wr_err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_credit();
    test_random();
`ifdef VFU_MEM_WSTRB_EN
    test_wstrb();
`endif
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
